ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter_pkg.sv | 20 ++
 rtl/ula_of_infinity.sv | 54 +++++
 rtl/ula_arbiter.sv | 115 +++++++++++
 tb/tb_ula_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_arbiter_pkg.sv
// Shared FSM encoding and ALU opcode constants for the
// two-requester ALU arbiter and its ula_of_infinity datapath.
package ula_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] ULA_OP_ADD = 4'd0;
    localparam logic [3:0] ULA_OP_SUB = 4'd1;
    localparam logic [3:0] ULA_OP_AND = 4'd2;
    localparam logic [3:0] ULA_OP_OR  = 4'd3;
    localparam logic [3:0] ULA_OP_XOR = 4'd4;
    localparam logic [3:0] ULA_OP_NOT = 4'd5;
    localparam logic [3:0] ULA_OP_SHL = 4'd6;
    localparam logic [3:0] ULA_OP_SHR = 4'd7;

endpackage

// File: rtl/ula_of_infinity.sv
// Combinational 8-bit ALU: result plus carry, signed overflow and zero.
// SUB reports cout=1 when no borrow occurs (a >= b, unsigned).
module ula_of_infinity
    import ula_arbiter_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_op,
    output logic [7:0] o_result,
    output logic       o_cout,
    output logic       o_overflow,
    output logic       o_zero
);

    logic [8:0] w_sum;
    logic [8:0] w_dif;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;

    always_comb begin
        o_result   = 8'd0;
        o_cout     = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            ULA_OP_ADD: begin
                o_result   = w_sum[7:0];
                o_cout     = w_sum[8];
                o_overflow = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
            end
            ULA_OP_SUB: begin
                o_result   = w_dif[7:0];
                o_cout     = w_dif[8];
                o_overflow = (i_a[7] != i_b[7]) && (w_dif[7] != i_a[7]);
            end
            ULA_OP_AND: o_result = i_a & i_b;
            ULA_OP_OR:  o_result = i_a | i_b;
            ULA_OP_XOR: o_result = i_a ^ i_b;
            ULA_OP_NOT: o_result = ~i_a;
            ULA_OP_SHL: begin
                o_result = {i_a[6:0], 1'b0};
                o_cout   = i_a[7];
            end
            ULA_OP_SHR: begin
                o_result = {1'b0, i_a[7:1]};
                o_cout   = i_a[0];
            end
            default: o_result = 8'd0;
        endcase
    end

    assign o_zero = (o_result == 8'd0);

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester front end for one ALU: arbitrate, execute, then hold
// the response until the consumer takes it (3 cycles per operation).
module ula_arbiter
    import ula_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_op,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_op,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_cout,
    output logic       rsp_overflow,
    output logic       rsp_zero,
    output logic [7:0] ops_done
);

    state_t     r_state;
    logic       r_last;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_op;
    logic       r_id;

    logic       w_any;
    logic       w_gnt_id;
    logic       w_accept;
    logic [7:0] w_res;
    logic       w_cout;
    logic       w_ovf;
    logic       w_zero;

    // On a tie, round-robin favours whoever was not granted last
    always_comb begin
        w_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            w_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
        else
            w_gnt_id = req1_valid;
        w_accept   = (r_state == IDLE) && w_any;
        req0_ready = w_accept && !w_gnt_id;
        req1_ready = w_accept && w_gnt_id;
    end

    ula_of_infinity u_ula (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_result   (w_res),
        .o_cout     (w_cout),
        .o_overflow (w_ovf),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_op         <= 4'd0;
            r_id         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 8'd0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            ops_done     <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt_id ? req1_a  : req0_a;
                        r_b     <= w_gnt_id ? req1_b  : req0_b;
                        r_op    <= w_gnt_id ? req1_op : req0_op;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result   <= w_res;
                    rsp_cout     <= w_cout;
                    rsp_overflow <= w_ovf;
                    rsp_zero     <= w_zero;
                    rsp_id       <= r_id;
                    rsp_valid    <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Randomised self-checking bench for ula_arbiter against a behavioural
// model (integer ALU arithmetic, last-grant bookkeeping, op counter).
module tb_ula_arbiter;
    import ula_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_op, req1_op;

    logic       rdy0, rdy1, rv, rid, rc, ro, rz;
    logic [7:0] rres, done;
    logic       f_rdy0, f_rdy1, f_rv, f_rid, f_c, f_o, f_z;
    logic [7:0] f_res, f_done;

    int n_checks = 0;
    int n_fail = 0;
    int m_last;
    int m_done;

    always #5 clk = ~clk;

    ula_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_ready(rdy0),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_ready(rdy1),
        .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid),
        .rsp_result(rres), .rsp_cout(rc), .rsp_overflow(ro),
        .rsp_zero(rz), .ops_done(done)
    );

    ula_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_ready(f_rdy0),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_ready(f_rdy1),
        .rsp_valid(f_rv), .rsp_ready(rsp_ready), .rsp_id(f_rid),
        .rsp_result(f_res), .rsp_cout(f_c), .rsp_overflow(f_o),
        .rsp_zero(f_z), .ops_done(f_done)
    );

    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int res, output bit c,
                                    output bit v, output bit z);
        int sa, sb, t;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        res = 0; c = 0; v = 0;
        case (op)
            0: begin
                t = a + b; res = t % 256; c = (t > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            1: begin
                t = a - b; res = (t + 256) % 256; c = (a >= b);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin res = (a * 2) % 256; c = (a >= 128); end
            7: begin res = a / 2; c = (a % 2 == 1); end
            default: res = 0;
        endcase
        z = (res == 0);
    endfunction

    function automatic int model_winner(input int pat);
        if (pat == 0) return 0;
        if (pat == 1) return 1;
        return (m_last == 0) ? 1 : 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = 8'd0; req0_b = 8'd0; req0_op = 4'd0;
        req1_a = 8'd0; req1_b = 8'd0; req1_op = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_last = 1;
        m_done = 0;
    endtask

    // pat: 0 = req0 only, 1 = req1 only, 2 = both
    task automatic run_op(input int pat,
                          input logic [7:0] a0, input logic [7:0] b0,
                          input logic [3:0] o0,
                          input logic [7:0] a1, input logic [7:0] b1,
                          input logic [3:0] o1,
                          output int lat, output logic id,
                          output logic [7:0] res, output logic c,
                          output logic v, output logic z, output bit tmo);
        int k;
        tmo = 0;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        req0_valid = (pat != 1);
        req1_valid = (pat != 0);
        rsp_ready = 1'b1;
        #1;
        k = 0;
        while (!(rdy0 | rdy1) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        if (k == 20) tmo = 1;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 0;
        while (!rv && k < 10) begin
            @(posedge clk); #1; k++;
        end
        if (k == 10) tmo = 1;
        id = rid; res = rres; c = rc; v = ro; z = rz;
        @(posedge clk); #1;
        lat = k + 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({rv, rid, rres, rc, ro, rz, done} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0",
                     {rv, rid, rres, rc, ro, rz, done});
        end
        n_checks++;
        if ({rdy0, rdy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle_ready got %b want 00", {rdy0, rdy1});
        end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_checks++;
        if ({rdy0, rdy1} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_tie got %b want 10", {rdy0, rdy1});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        int lat; logic id, c, v, z; logic [7:0] res; bit tmo;
        do_reset();
        run_op(0, 8'd100, 8'd27, ULA_OP_ADD, 8'd0, 8'd0, 4'd0,
               lat, id, res, c, v, z, tmo);
        m_last = 0; m_done = 1;
        n_checks++;
        if (tmo || res !== 8'd127 || v !== 1'b0 || id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_add got res=%0d v=%b id=%b tmo=%0d want 127 0 0",
                     res, v, id, tmo);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL single_add_latency got %0d want 2", lat);
        end
        n_checks++;
        if (done !== 8'd1) begin
            n_fail++;
            $display("FAIL single_add_done got %0d want 1", done);
        end
    endtask

    task automatic test_overflow_zero();
        int lat; logic id, c, v, z; logic [7:0] res; bit tmo;
        run_op(1, 8'd0, 8'd0, 4'd0, 8'd100, 8'd28, ULA_OP_ADD,
               lat, id, res, c, v, z, tmo);
        m_last = 1; m_done++;
        n_checks++;
        if (tmo || res !== 8'd128 || v !== 1'b1 || id !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow got res=%0d v=%b id=%b want 128 1 1",
                     res, v, id);
        end
        run_op(0, 8'd5, 8'd5, ULA_OP_SUB, 8'd0, 8'd0, 4'd0,
               lat, id, res, c, v, z, tmo);
        m_last = 0; m_done++;
        n_checks++;
        if (tmo || res !== 8'd0 || z !== 1'b1 || c !== 1'b1 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_zero got res=%0d z=%b c=%b v=%b want 0 1 1 0",
                     res, z, c, v);
        end
        n_checks++;
        if (done !== 8'(m_done)) begin
            n_fail++;
            $display("FAIL overflow_done got %0d want %0d", done, m_done);
        end
    endtask

    task automatic test_round_robin();
        logic q_rr[$];
        logic q_fp[$];
        int t_rr[$];
        do_reset();
        req0_a = 8'd1; req0_b = 8'd2; req0_op = ULA_OP_ADD;
        req1_a = 8'd9; req1_b = 8'd4; req1_op = ULA_OP_SUB;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rv && q_rr.size() < 4) begin
                q_rr.push_back(rid);
                t_rr.push_back(i);
            end
            if (f_rv && q_fp.size() < 4) q_fp.push_back(f_rid);
            if (q_rr.size() >= 4 && q_fp.size() >= 4) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if (q_rr.size() != 4 || q_fp.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count got %0d/%0d want 4/4",
                     q_rr.size(), q_fp.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_rr[i] !== model_winner(2)) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d] got %b want %0d",
                             i, q_rr[i], model_winner(2));
                end
                m_last = model_winner(2);
                n_checks++;
                if (q_fp[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fixed_grant[%0d] got %b want 0", i, q_fp[i]);
                end
                n_checks++;
                if (t_rr[i] !== 1 + 3 * i) begin
                    n_fail++;
                    $display("FAIL rr_throughput[%0d] got cycle %0d want %0d",
                             i, t_rr[i], 1 + 3 * i);
                end
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [11:0] snap;
        logic [7:0] d0;
        do_reset();
        req0_a = 8'd200; req0_b = 8'd100; req0_op = ULA_OP_ADD;
        req0_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        snap = {rv, rid, rres, rc, ro};
        d0 = done;
        n_checks++;
        if (snap !== {1'b1, 1'b0, 8'd44, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_resp got %h want %h", snap,
                     {1'b1, 1'b0, 8'd44, 1'b1, 1'b0});
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rv, rid, rres, rc, ro} !== snap || {rdy0, rdy1} !== 2'b00
                || done !== d0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got %h rdy=%b done=%0d want %h 00 %0d",
                         i, {rv, rid, rres, rc, ro}, {rdy0, rdy1}, done, snap, d0);
            end
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rv !== 1'b0 || done !== d0 + 8'd1 || {rdy0, rdy1} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got rv=%b done=%0d rdy=%b want 0 %0d 01",
                     rv, done, {rdy0, rdy1}, d0 + 8'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req0_a = 8'd3; req0_b = 8'd4; req0_op = ULA_OP_ADD;
        req1_valid = 1'b1;
        req1_a = 8'd5; req1_b = 8'd6; req1_op = ULA_OP_ADD;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (rv !== 1'b0 || done !== 8'd0) begin
            n_fail++;
            $display("FAIL midop_reset got rv=%b done=%0d want 0 0", rv, done);
        end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_checks++;
        if ({rdy0, rdy1} !== 2'b10) begin
            n_fail++;
            $display("FAIL midop_tie got %b want 10", {rdy0, rdy1});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (rv !== 1'b0 || done !== 8'd0) begin
                n_fail++;
                $display("FAIL midop_no_resp got rv=%b done=%0d want 0 0",
                         rv, done);
            end
        end
    endtask

    task automatic test_random();
        int lat, pat, w, ea, eb, eo, eres;
        logic id, c, v, z; logic [7:0] res; bit tmo, ec, ev, ez;
        logic [7:0] a0, b0, a1, b1; logic [3:0] o0, o1;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            pat = $urandom_range(0, 2);
            a0 = 8'($urandom); b0 = 8'($urandom); o0 = 4'($urandom_range(0, 7));
            a1 = 8'($urandom); b1 = 8'($urandom); o1 = 4'($urandom_range(0, 7));
            run_op(pat, a0, b0, o0, a1, b1, o1, lat, id, res, c, v, z, tmo);
            w = model_winner(pat);
            ea = (w == 0) ? int'(a0) : int'(a1);
            eb = (w == 0) ? int'(b0) : int'(b1);
            eo = (w == 0) ? int'(o0) : int'(o1);
            ref_alu(ea, eb, eo, eres, ec, ev, ez);
            m_last = w;
            m_done = (m_done + 1) % 256;
            n_checks++;
            if (tmo || id !== 1'(w) || res !== 8'(eres) || c !== ec
                || v !== ev || z !== ez || lat !== 2 || done !== 8'(m_done)) begin
                n_fail++;
                $display("FAIL random[%0d] got id=%b res=%0d c=%b v=%b z=%b lat=%0d done=%0d want %0d %0d %b %b %b 2 %0d",
                         n, id, res, c, v, z, lat, done, w, eres, ec, ev, ez, m_done);
            end
        end
    endtask

    task automatic test_wrap();
        int lat; logic id, c, v, z; logic [7:0] res; bit tmo;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            run_op(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)),
                   8'd0, 8'd0, 4'd0, lat, id, res, c, v, z, tmo);
            m_done = (m_done + 1) % 256;
            if (n == 254 || n == 255 || tmo) begin
                n_checks++;
                if (tmo || done !== 8'(m_done)) begin
                    n_fail++;
                    $display("FAIL wrap[%0d] got %0d want %0d tmo=%0d",
                             n, done, m_done, tmo);
                end
                if (tmo) break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow_zero();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
